dmem_ctrl: RTL



---
 rtl/dmem_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the mem stage.
// Direct-mapped, one-word-line, write-through, no-write-allocate cache.
// An in-order FIFO holds load misses and stores and drains them to a
// single-outstanding external bus. Load-miss fills come back to the mem
// stage as load_done_stall pulses.
// Optional feature macro: DMEM_PERF_EN adds hit/miss/stall pulse counters.
module dmem_ctrl #(
  parameter int LINES      = 64,
  parameter int MSHR_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_req,
  input  logic        mmio_lw,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_data_write,
  input  logic [4:0]  mmio_regD,
  output logic [31:0] mmio_data_read,
  output logic        hit_ack,
  output logic        miss_store,
  output logic        load_done_stall,
  output logic        passive_stall,
  output logic [4:0]  regD_done,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses,
  output logic [31:0] perf_stalls
`endif
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;
  localparam int PW  = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
  localparam int CW  = $clog2(MSHR_DEPTH + 1);

  // One FIFO entry: word address, store data, load destination.
  typedef struct packed {
    logic        we;
    logic [29:0] waddr;
    logic [31:0] data;
    logic [4:0]  rd;
  } mshr_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} bus_st_t;

  // Cache state
  logic [LINES-1:0] line_vld;
  logic [TW-1:0]    line_tag  [LINES];
  logic [31:0]      line_data [LINES];

  // Miss/store FIFO state
  mshr_t            fifo [MSHR_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;

  bus_st_t          st;

  // Byte offset is never used; the name keeps lint quiet about it.
  logic             unused_addr_lsb;
  assign unused_addr_lsb = ^mmio_addr[1:0];

  // Request decode against the cache
  logic [IDX-1:0] req_idx;
  logic [TW-1:0]  req_tag;
  logic           req_hit;
  assign req_idx = mmio_addr[IDX+1:2];
  assign req_tag = mmio_addr[31:IDX+2];
  assign req_hit = line_vld[req_idx] && (line_tag[req_idx] == req_tag);

  // Head-of-FIFO decode; head stays put until it is popped
  mshr_t          head;
  logic [IDX-1:0] head_idx;
  logic [TW-1:0]  head_tag;
  logic           head_hit;
  assign head     = fifo[rd_ptr];
  assign head_idx = head.waddr[IDX-1:0];
  assign head_tag = head.waddr[29:IDX];
  assign head_hit = line_vld[head_idx] && (line_tag[head_idx] == head_tag);

  // Per-cycle events. A completing fill owns the cycle: any concurrent
  // request is dropped without side effects and the mem stage retries.
  logic fill, wr_acc, full, take, enq, deq, store_upd;
  assign fill      = (st == S_WAIT_R) && bus_rvalid;
  assign wr_acc    = (st == S_REQ) && bus_ready && bus_we;
  assign full      = (cnt == CW'(MSHR_DEPTH));
  assign take      = mmio_req && !fill;
  assign enq       = take && !full && (!mmio_lw || !req_hit);
  assign deq       = wr_acc || fill;
  assign store_upd = take && !full && !mmio_lw && req_hit;

  // Registered response flags and data, one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_ack         <= 1'b0;
      miss_store      <= 1'b0;
      passive_stall   <= 1'b0;
      load_done_stall <= 1'b0;
      regD_done       <= '0;
      mmio_data_read  <= '0;
    end else begin
      hit_ack         <= take && req_hit && (mmio_lw || !full);
      miss_store      <= take && mmio_lw && !req_hit && !full;
      passive_stall   <= take && full && !(mmio_lw && req_hit);
      load_done_stall <= fill;
      regD_done       <= fill ? head.rd : 5'd0;
      if (fill)
        mmio_data_read <= bus_rdata;
      else if (take && mmio_lw && req_hit)
        mmio_data_read <= line_data[req_idx];
      else
        mmio_data_read <= '0;
    end
  end

  // Line valid bits: only fills allocate, reset invalidates everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_vld <= '0;
    else if (fill) line_vld[head_idx] <= 1'b1;
  end

  // Line tag/data. A store hit is newer than the store being written out,
  // so it wins when both land on the same line in one cycle.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[head_idx]  <= head_tag;
      line_data[head_idx] <= bus_rdata;
    end else begin
      if (wr_acc && head_hit && !(store_upd && (req_idx == head_idx)))
        line_data[head_idx] <= head.data;
      if (store_upd)
        line_data[req_idx] <= mmio_data_write;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo[wr_ptr].we    <= !mmio_lw;
      fifo[wr_ptr].waddr <= mmio_addr[31:2];
      fifo[wr_ptr].data  <= mmio_lw ? 32'd0 : mmio_data_write;
      fifo[wr_ptr].rd    <= mmio_lw ? mmio_regD : 5'd0;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PW'(MSHR_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= (rd_ptr == PW'(MSHR_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Bus FSM: present head entry, hold until accepted, wait for read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (cnt != '0) begin
            st        <= S_REQ;
            bus_req   <= 1'b1;
            bus_we    <= head.we;
            bus_addr  <= {head.waddr, 2'b00};
            bus_wdata <= head.data;
          end
        end
        S_REQ: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            st      <= bus_we ? S_IDLE : S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (bus_rvalid) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_PERF_EN
  // Pulse counters over the registered response flags, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits   <= '0;
      perf_misses <= '0;
      perf_stalls <= '0;
    end else begin
      perf_hits   <= perf_hits   + 32'(hit_ack);
      perf_misses <= perf_misses + 32'(miss_store);
      perf_stalls <= perf_stalls + 32'(passive_stall);
    end
  end
`endif

endmodule
